// File: rtl/demosaic_root_mul_pipe_if.sv
// Handshake and data bundle for demosaic_root_mul_pipe.
// The slave modport is the multiplier side. The master modport is the producer/consumer side.
interface demosaic_root_mul_pipe_if #(
   parameter int din0_WIDTH = 18,
   parameter int din1_WIDTH = 8,
   parameter int dout_WIDTH = 25
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [din0_WIDTH-1:0] din0;
   logic [din1_WIDTH-1:0] din1;
   logic                  in_signed;
   logic                  out_valid;
   logic                  out_ready;
   logic [dout_WIDTH-1:0] dout;
   logic                  out_sat;

   modport master (
      output in_valid, din0, din1, in_signed, out_ready,
      input  in_ready, out_valid, dout, out_sat
   );

   modport slave (
      input  in_valid, din0, din1, in_signed, out_ready,
      output in_ready, out_valid, dout, out_sat
   );
endinterface

// File: rtl/demosaic_root_mul_pipe.sv
// Pipelined signed/unsigned multiplier with round, shift and fit to dout_WIDTH, using valid/ready flow control.
// Define DEMOSAIC_MUL_SAT_EN to clamp the result (and flag out_sat) instead of truncating it.
module demosaic_root_mul_pipe #(
   parameter int din0_WIDTH = 18,
   parameter int din1_WIDTH = 8,
   parameter int dout_WIDTH = 25,
   parameter int NUM_STAGE  = 3,
   parameter int SHIFT      = 0
) (
   input logic ap_clk,
   input logic ap_rst_n,
   demosaic_root_mul_pipe_if.slave bus
);
   localparam int PW = din0_WIDTH + din1_WIDTH;
   localparam logic [PW:0] RND = (SHIFT == 0) ? '0 :
                                 ({{PW{1'b0}}, 1'b1} << ((SHIFT == 0) ? 0 : SHIFT - 1));

   function automatic logic [PW-1:0] mul(input logic [din0_WIDTH-1:0] a,
                                         input logic [din1_WIDTH-1:0] b,
                                         input logic sgn);
      logic [PW-1:0] ax;
      logic [PW-1:0] bx;
      ax = sgn ? {{din1_WIDTH{a[din0_WIDTH-1]}}, a} : {{din1_WIDTH{1'b0}}, a};
      bx = sgn ? {{din0_WIDTH{b[din1_WIDTH-1]}}, b} : {{din0_WIDTH{1'b0}}, b};
      return ax * bx;
   endfunction

   // The round add is done one bit wider than P, so it cannot overflow. The result is {sat, dout}.
   function automatic logic [dout_WIDTH:0] fit(input logic [PW-1:0] p, input logic sgn);
      logic        [PW:0] px;
      logic signed [PW:0] rs;
      logic        [PW:0] r;
`ifdef DEMOSAIC_MUL_SAT_EN
      logic               over;
`endif
      px = {sgn & p[PW-1], p} + RND;
      rs = $signed(px) >>> SHIFT;
      r  = sgn ? rs : (px >> SHIFT);
`ifdef DEMOSAIC_MUL_SAT_EN
      if (sgn)
         over = !((&r[PW:dout_WIDTH-1]) || !(|r[PW:dout_WIDTH-1]));
      else
         over = |r[PW:dout_WIDTH];
      if (!over)
         return {1'b0, r[dout_WIDTH-1:0]};
      else if (sgn)
         return {1'b1, r[PW], {(dout_WIDTH-1){~r[PW]}}};
      else
         return {1'b1, {dout_WIDTH{1'b1}}};
`else
      return {1'b0, r[dout_WIDTH-1:0]};
`endif
   endfunction

   logic [NUM_STAGE:1]    v;
   logic [NUM_STAGE:1]    load;
   logic [dout_WIDTH-1:0] dout_q;
   logic                  sat_q;

   // A stage may load when it, or any stage after it, holds a bubble, or when the consumer is taking data.
   always_comb begin
      load = '0;
      for (int k = 1; k <= NUM_STAGE; k++) begin
         load[k] = bus.out_ready;
         for (int j = k; j <= NUM_STAGE; j++)
            if (!v[j]) load[k] = 1'b1;
      end
   end

   assign bus.in_ready  = load[1];
   assign bus.out_valid = v[NUM_STAGE];
   assign bus.dout      = dout_q;
   assign bus.out_sat   = sat_q;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         v <= '0;
      end else begin
         if (load[1]) v[1] <= bus.in_valid;
         for (int k = 2; k <= NUM_STAGE; k++)
            if (load[k]) v[k] <= v[k-1];
      end
   end

   generate
      if (NUM_STAGE == 1) begin : g_single
         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               dout_q <= '0;
               sat_q  <= 1'b0;
            end else if (load[1] && bus.in_valid) begin
               {sat_q, dout_q} <= fit(mul(bus.din0, bus.din1, bus.in_signed), bus.in_signed);
            end
         end
      end else begin : g_multi
         logic [PW-1:0] p_q [1:NUM_STAGE-1];
         logic          s_q [1:NUM_STAGE-1];

         // Product and delay registers carry no reset, so retiming can move them freely.
         always_ff @(posedge ap_clk) begin
            if (load[1] && bus.in_valid) begin
               p_q[1] <= mul(bus.din0, bus.din1, bus.in_signed);
               s_q[1] <= bus.in_signed;
            end
            for (int k = 2; k < NUM_STAGE; k++) begin
               if (load[k] && v[k-1]) begin
                  p_q[k] <= p_q[k-1];
                  s_q[k] <= s_q[k-1];
               end
            end
         end

         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               dout_q <= '0;
               sat_q  <= 1'b0;
            end else if (load[NUM_STAGE] && v[NUM_STAGE-1]) begin
               {sat_q, dout_q} <= fit(p_q[NUM_STAGE-1], s_q[NUM_STAGE-1]);
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_demosaic_root_mul_pipe.sv
// Self-checking bench for demosaic_root_mul_pipe: three lanes (N=3/S=0, N=1/S=4/W=20, N=5/S=2) against an integer model.
// Expectations follow DEMOSAIC_MUL_SAT_EN when it is defined.
module tb_demosaic_root_mul_pipe;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [2:0]  iv;
   logic [2:0]  ord;
   logic [2:0]  sg;
   logic [17:0] a [3];
   logic [7:0]  b [3];
   logic [2:0]  ir;
   logic [2:0]  ov;
   logic [2:0]  os;
   logic [24:0] od [3];

   int errors = 0;
   int checks = 0;
   int acc [3];
   int head [3];
   int tail [3];
   logic [25:0] exp_mem [3][16];

   function automatic int stages_of(input int i);
      return (i == 0) ? 3 : (i == 1) ? 1 : 5;
   endfunction
   function automatic int shift_of(input int i);
      return (i == 0) ? 0 : (i == 1) ? 4 : 2;
   endfunction
   function automatic int width_of(input int i);
      return (i == 1) ? 20 : 25;
   endfunction

   generate
      for (genvar g = 0; g < 3; g++) begin : lane
         localparam int N  = (g == 0) ? 3 : (g == 1) ? 1 : 5;
         localparam int SH = (g == 0) ? 0 : (g == 1) ? 4 : 2;
         localparam int DW = (g == 1) ? 20 : 25;
         demosaic_root_mul_pipe_if #(.din0_WIDTH(18), .din1_WIDTH(8), .dout_WIDTH(DW)) bus ();
         assign bus.in_valid  = iv[g];
         assign bus.din0      = a[g];
         assign bus.din1      = b[g];
         assign bus.in_signed = sg[g];
         assign bus.out_ready = ord[g];
         assign ir[g]         = bus.in_ready;
         assign ov[g]         = bus.out_valid;
         assign os[g]         = bus.out_sat;
         assign od[g]         = 25'(bus.dout);
         demosaic_root_mul_pipe #(
            .din0_WIDTH(18), .din1_WIDTH(8), .dout_WIDTH(DW), .NUM_STAGE(N), .SHIFT(SH)
         ) dut (
            .ap_clk(clk),
            .ap_rst_n(rst_n),
            .bus(bus.slave)
         );
      end
   endgenerate

   // Exact integer arithmetic: product, round half up, then clamp or wrap.
   function automatic logic [25:0] model(input logic [17:0] av, input logic [7:0] bv,
                                         input logic s, input int sh, input int dw);
      longint x, y, r, lo, hi;
      logic   sat;
      x = s ? longint'($signed(av)) : longint'(av);
      y = s ? longint'($signed(bv)) : longint'(bv);
      r = x * y;
      if (sh > 0) r = (r + (longint'(1) <<< (sh - 1))) >>> sh;
      if (s) begin
         lo = -(longint'(1) <<< (dw - 1));
         hi = (longint'(1) <<< (dw - 1)) - 1;
      end else begin
         lo = 0;
         hi = (longint'(1) <<< dw) - 1;
      end
      sat = 1'b0;
`ifdef DEMOSAIC_MUL_SAT_EN
      if (r > hi) begin r = hi; sat = 1'b1; end
      else if (r < lo) begin r = lo; sat = 1'b1; end
`endif
      return {sat, 25'(r & ((longint'(1) <<< dw) - 1))};
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got timeout expected completion", name);
   endtask

   // The single compare process, run on every falling edge: it checks in_ready, the result order and values, and that outputs are held during stalls.
   initial begin
      logic        prev_stall [3];
      logic [25:0] prev_out [3];
      int          occ;
      for (int i = 0; i < 3; i++) begin
         acc[i] = 0; head[i] = 0; tail[i] = 0; prev_stall[i] = 1'b0; prev_out[i] = '0;
      end
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
               head[i] = 0; tail[i] = 0; prev_stall[i] = 1'b0;
            end
         end else begin
            for (int i = 0; i < 3; i++) begin
               occ = tail[i] - head[i];
               check_output($sformatf("in_ready lane%0d", i), 64'(ir[i]),
                            64'(!(occ == stages_of(i) && !ord[i])));
               if (prev_stall[i])
                  check_output($sformatf("stall hold lane%0d", i), {ov[i], os[i], od[i]},
                               {1'b1, prev_out[i]});
               if (ov[i] && occ == 0) begin
                  checks++; errors++;
                  $display("[TB] FAIL spurious lane%0d: got dout %0h expected no result", i, od[i]);
               end else if (ov[i] && ord[i]) begin
                  check_output($sformatf("result lane%0d", i), {os[i], od[i]}, exp_mem[i][head[i] % 16]);
                  head[i]++;
               end
               prev_stall[i] = ov[i] && !ord[i];
               prev_out[i]   = {os[i], od[i]};
               if (iv[i] && ir[i]) begin
                  exp_mem[i][tail[i] % 16] = model(a[i], b[i], sg[i], shift_of(i), width_of(i));
                  tail[i]++;
                  acc[i]++;
               end
            end
         end
      end
   end

   // Call at posedge+1. Holds the operands until the lane accepts them. Returns at posedge+1 after the accept edge.
   task automatic apply_stimulus(input int ln, input logic [17:0] av, input logic [7:0] bv, input logic s);
      a[ln] = av; b[ln] = bv; sg[ln] = s; iv[ln] = 1'b1;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (ir[ln]) begin
            @(posedge clk); #1;
            iv[ln] = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      iv[ln] = 1'b0;
      timeout($sformatf("accept lane%0d", ln));
   endtask

   task automatic expect_result(input int ln, input logic [24:0] ed, input logic es, input string name);
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (ov[ln]) begin
            check_output({name, " dout"}, 64'(od[ln]), 64'(ed));
            check_output({name, " sat"}, 64'(os[ln]), 64'(es));
            @(posedge clk); #1;
            return;
         end
      end
      timeout(name);
   endtask

   initial begin
      int  base [3];
      bit  done;
      rst_n = 1'b0; iv = '0; ord = '1; sg = '0;
      for (int i = 0; i < 3; i++) begin a[i] = '0; b[i] = '0; end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         check_output($sformatf("reset in_ready%0d", i), 64'(ir[i]), 64'd1);
         check_output($sformatf("reset out%0d", i), {ov[i], os[i], od[i]}, 64'd0);
      end

      check_output("model 1000x200", 64'(model(18'd1000, 8'd200, 1'b0, 0, 25)), 64'd200000);
      check_output("model 100x3 s4", 64'(model(18'd100, 8'd3, 1'b0, 4, 20)), 64'd19);
      check_output("model -7x3 s2", 64'(model(18'h3FFF9, 8'd3, 1'b1, 2, 25)), 64'h1FFFFFB);

      apply_stimulus(0, 18'd1000, 8'd200, 1'b0);
      check_output("latency +0", 64'(ov[0]), 64'd0);
      @(posedge clk); #1;
      check_output("latency +1", 64'(ov[0]), 64'd0);
      @(posedge clk); #1;
      check_output("latency +2", {ov[0], os[0], od[0]}, {1'b1, 1'b0, 25'd200000});
      @(posedge clk); #1;

`ifdef DEMOSAIC_MUL_SAT_EN
      apply_stimulus(0, 18'd262143, 8'd255, 1'b0);
      expect_result(0, 25'd33554431, 1'b1, "unsigned overflow");
      apply_stimulus(0, 18'h20000, 8'h80, 1'b1);
      expect_result(0, 25'd16777215, 1'b1, "signed overflow");
`else
      apply_stimulus(0, 18'd262143, 8'd255, 1'b0);
      expect_result(0, 25'd33292033, 1'b0, "unsigned overflow");
      apply_stimulus(0, 18'h20000, 8'h80, 1'b1);
      expect_result(0, 25'h1000000, 1'b0, "signed overflow");
`endif
      apply_stimulus(1, 18'd100, 8'd3, 1'b0);
      expect_result(1, 25'd19, 1'b0, "round shift4");
      apply_stimulus(2, 18'h3FFF9, 8'd3, 1'b1);
      expect_result(2, 25'h1FFFFFB, 1'b0, "round shift2");

      // Random traffic on all lanes with 50% valid and 50% ready.
      for (int i = 0; i < 3; i++) base[i] = acc[i];
      done = 1'b0;
      for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
         done = 1'b1;
         for (int i = 0; i < 3; i++) begin
            if (acc[i] - base[i] < 20) begin
               done   = 1'b0;
               iv[i]  = 1'($urandom_range(0, 1));
               a[i]   = 18'($urandom);
               b[i]   = 8'($urandom);
               sg[i]  = 1'($urandom_range(0, 1));
            end else begin
               iv[i] = 1'b0;
            end
            ord[i] = 1'($urandom_range(0, 1));
         end
         if (!done) begin
            @(posedge clk); #1;
         end
      end
      if (!done) timeout("random stream");
      iv = '0; ord = '1;
      for (int t = 0; t < 50; t++) begin
         if (tail[0] == head[0] && tail[1] == head[1] && tail[2] == head[2]) break;
         @(posedge clk); #1;
      end
      for (int i = 0; i < 3; i++)
         check_output($sformatf("drain lane%0d", i), 64'(tail[i] - head[i]), 64'd0);

      ord[0] = 1'b0;
      apply_stimulus(0, 18'd11, 8'd2, 1'b0);
      apply_stimulus(0, 18'd12, 8'd3, 1'b0);
      apply_stimulus(0, 18'd13, 8'd4, 1'b0);
      check_output("full stalled", {ov[0], ir[0]}, 64'b10);
      #1 rst_n = 1'b0;
      #1;
      check_output("async reset out", {ov[0], os[0], od[0]}, 64'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      ord[0] = 1'b1;
      apply_stimulus(0, 18'd5, 8'd5, 1'b0);
      expect_result(0, 25'd25, 1'b0, "post-reset 5x5");
      repeat (6) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
